game: RTL and testbench

GAME -- requirements
Module: game

---
 rtl/game_pkg.sv | 22 ++
 rtl/game_lfsr10.sv | 18 +
 rtl/game.sv | 134 +++++++++++++
 tb/tb_game.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the penalty-shootout game.
package game_pkg;

    typedef enum logic [2:0] {IDLE, AIM, FLIGHT, RESULT, OVER} state_t;

    localparam logic [3:0] GOAL_LEFT  = 4'd4;
    localparam logic [3:0] GOAL_RIGHT = 4'd11;
    localparam logic [3:0] KICK_Y     = 4'd14;
    localparam logic [3:0] KEEPER_Y   = 4'd1;
    localparam logic [3:0] CENTER_X   = 4'd7;

    localparam int LFSR_TAP_HI = 9;
    localparam int LFSR_TAP_LO = 6;

    // Crossbar spans x 3..12, i.e. bits 12..3 of a row (bit 15 is x=0).
    localparam logic [15:0] BAR_ROW = 16'h1FF8;

    function automatic logic near(input logic [3:0] a, input logic [3:0] b);
        return (a <= b + 4'd1) && (b <= a + 4'd1);
    endfunction

endpackage

// File: rtl/game_lfsr10.sv
// 10-bit Fibonacci LFSR, XNOR feedback so the all-zero reset state is legal.
module lfsr10
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       RST,
    output logic [9:0] out
);

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            out <= '0;
        end else begin
            out <= {out[8:0], ~(out[LFSR_TAP_HI] ^ out[LFSR_TAP_LO])};
        end
    end

endmodule

// File: rtl/game.sv
// Penalty-shootout game controller with 16x16 red/green pixel output.
// Optional: define PENALTY_GOAL_FLASH_EN to flash the goal area during RESULT.
//
// state  | meaning
// IDLE   | after reset, waiting for start; only the crossbar is drawn
// AIM    | ball on the kick spot, left/right move it, shoot kicks
// FLIGHT | ball rises one row per cycle, keeper walks toward its target
// RESULT | one cycle showing the outcome of the shot
// OVER   | all shots used, waiting for start
module game
    import game_pkg::*;
#(
    parameter int MAX_SHOTS = 5
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic              left,
    input  logic              right,
    input  logic              shoot,
    output logic [15:0][15:0] RedPixels,
    output logic [15:0][15:0] GrnPixels,
    output logic [2:0]        score,
    output logic [2:0]        shots_num,
    output logic [3:0]        player_x,
    output logic [3:0]        player_y,
    output logic [3:0]        goalkeeper_x,
    output logic [9:0]        check
);

    localparam logic [2:0] SHOTS_LAST = 3'(MAX_SHOTS);

    state_t     state;
    logic [3:0] target;
    logic       goal;

    lfsr10 u_lfsr (
        .clk (clk),
        .RST (RST),
        .out (check)
    );

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            score        <= '0;
            shots_num    <= '0;
            player_x     <= CENTER_X;
            player_y     <= KICK_Y;
            goalkeeper_x <= CENTER_X;
            target       <= CENTER_X;
            goal         <= 1'b0;
        end else if (start) begin
            state        <= AIM;
            score        <= '0;
            shots_num    <= '0;
            player_x     <= CENTER_X;
            player_y     <= KICK_Y;
            goalkeeper_x <= CENTER_X;
            goal         <= 1'b0;
        end else begin
            case (state)
                AIM: begin
                    if (shoot) begin
                        target    <= GOAL_LEFT + {1'b0, check[2:0]};
                        shots_num <= shots_num + 3'd1;
                        state     <= FLIGHT;
                    end else if (left && !right && player_x > GOAL_LEFT) begin
                        player_x <= player_x - 4'd1;
                    end else if (right && !left && player_x < GOAL_RIGHT) begin
                        player_x <= player_x + 4'd1;
                    end
                end
                FLIGHT: begin
                    // Outcome is judged once the ball sits on the keeper row.
                    if (player_y == KEEPER_Y) begin
                        goal  <= !near(player_x, goalkeeper_x);
                        if (!near(player_x, goalkeeper_x)) begin
                            score <= score + 3'd1;
                        end
                        state <= RESULT;
                    end else begin
                        player_y <= player_y - 4'd1;
                        if (goalkeeper_x < target) begin
                            goalkeeper_x <= goalkeeper_x + 4'd1;
                        end else if (goalkeeper_x > target) begin
                            goalkeeper_x <= goalkeeper_x - 4'd1;
                        end
                    end
                end
                RESULT: begin
                    if (shots_num == SHOTS_LAST) begin
                        state <= OVER;
                    end else begin
                        state        <= AIM;
                        player_y     <= KICK_Y;
                        goalkeeper_x <= CENTER_X;
                    end
                end
                IDLE, OVER: begin
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        GrnPixels    = '0;
        RedPixels    = '0;
        GrnPixels[0] = BAR_ROW;
        if (state != IDLE) begin
            GrnPixels[player_y][4'd15 - player_x]          = 1'b1;
            RedPixels[KEEPER_Y][4'd15 - goalkeeper_x + 4'd1] = 1'b1;
            RedPixels[KEEPER_Y][4'd15 - goalkeeper_x]        = 1'b1;
            RedPixels[KEEPER_Y][4'd14 - goalkeeper_x]        = 1'b1;
        end
`ifdef PENALTY_GOAL_FLASH_EN
        if (state == RESULT) begin
            if (goal) begin
                GrnPixels[0] = GrnPixels[0] | BAR_ROW;
                GrnPixels[1] = GrnPixels[1] | BAR_ROW;
                RedPixels[0] = RedPixels[0] & ~BAR_ROW;
                RedPixels[1] = RedPixels[1] & ~BAR_ROW;
            end else begin
                RedPixels[0] = RedPixels[0] | BAR_ROW;
                RedPixels[1] = RedPixels[1] | BAR_ROW;
                GrnPixels[0] = GrnPixels[0] & ~BAR_ROW;
                GrnPixels[1] = GrnPixels[1] & ~BAR_ROW;
            end
        end
`endif
    end

endmodule

// File: tb/tb_game.sv
// Directed self-checking bench for the penalty-shootout game.
module tb_game;

    logic              clk = 1'b0;
    logic              RST = 1'b0;
    logic              start = 1'b0;
    logic              left = 1'b0;
    logic              right = 1'b0;
    logic              shoot = 1'b0;
    logic [15:0][15:0] red;
    logic [15:0][15:0] grn;
    logic [2:0]        score;
    logic [2:0]        shots_num;
    logic [3:0]        player_x;
    logic [3:0]        player_y;
    logic [3:0]        goalkeeper_x;
    logic [9:0]        check;

    int n_checks = 0;
    int n_pass   = 0;

    logic [9:0] m;
    int         exp_px;
    int         exp_score;
    int         exp_shots;

    game #(.MAX_SHOTS(5)) dut (
        .clk          (clk),
        .RST          (RST),
        .start        (start),
        .left         (left),
        .right        (right),
        .shoot        (shoot),
        .RedPixels    (red),
        .GrnPixels    (grn),
        .score        (score),
        .shots_num    (shots_num),
        .player_x     (player_x),
        .player_y     (player_y),
        .goalkeeper_x (goalkeeper_x),
        .check        (check)
    );

    always #5 clk = ~clk;

    // Reference LFSR: new bit0 = XNOR(bit9, bit6), shift left.
    always @(posedge clk or negedge RST) begin
        if (!RST) m <= '0;
        else      m <= {m[8:0], ~(m[9] ^ m[6])};
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0][15:0] grn_map(input int px, input int py, input bit show);
        logic [15:0][15:0] p;
        p = '0;
        p[0] = 16'h1FF8;
        if (show) p[py] = p[py] | (16'h8000 >> px);
        return p;
    endfunction

    function automatic logic [15:0][15:0] red_map(input int gk, input bit show);
        logic [15:0][15:0] p;
        p = '0;
        if (show) p[1] = 16'h0007 << (14 - gk);
        return p;
    endfunction

    task automatic move(input bit l, input bit r, input int n);
        for (int i = 0; i < n; i++) begin
            left = l; right = r;
            tick();
        end
        left = 0; right = 0;
    endtask

    task automatic take_shot(input bit with_left);
        int  tgt;
        int  d;
        bit  is_goal;
        logic [15:0][15:0] eg;
        logic [15:0][15:0] er;
        tgt = 4 + int'(m[2:0]);
        d = exp_px - tgt;
        is_goal = !(d >= -1 && d <= 1);
        shoot = 1; left = with_left;
        tick();
        shoot = 0; left = 0;
        exp_shots++;
        chk("shots_after_kick", shots_num, exp_shots);
        chk("px_held_on_kick", player_x, exp_px);
        tick();
        chk("py_first_step", player_y, 13);
        repeat (11) tick();
        chk("py_before_end", player_y, 2);
        tick();
        chk("py_at_keeper_row", player_y, 1);
        chk("keeper_at_target", goalkeeper_x, tgt);
        tick();
        if (is_goal) exp_score++;
        chk("score_after_shot", score, exp_score);
`ifdef PENALTY_GOAL_FLASH_EN
        eg = '0; er = '0;
        if (is_goal) begin eg[0] = 16'h1FF8; eg[1] = 16'h1FF8; end
        else         begin er[0] = 16'h1FF8; er[1] = 16'h1FF8; end
`else
        eg = grn_map(exp_px, 1, 1);
        er = red_map(tgt, 1);
`endif
        chk("result_grn", grn, eg);
        chk("result_red", red, er);
        tick();
        if (exp_shots < 5) begin
            chk("py_back_to_kick", player_y, 14);
            chk("keeper_back_center", goalkeeper_x, 7);
            chk("px_kept", player_x, exp_px);
        end
    endtask

    initial begin
        exp_px = 7; exp_score = 0; exp_shots = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_px", player_x, 7);
        chk("rst_py", player_y, 14);
        chk("rst_gk", goalkeeper_x, 7);
        chk("rst_score", score, 0);
        chk("rst_shots", shots_num, 0);
        chk("rst_check", check, 0);
        chk("rst_grn", grn, grn_map(0, 0, 0));
        chk("rst_red", red, red_map(0, 0));

        RST = 1;
        chk("rel_check0", check, 0);
        tick(); chk("lfsr_1", check, 1);
        tick(); chk("lfsr_3", check, 3);
        tick(); chk("lfsr_7", check, 7);
        right = 1; tick(); right = 0;
        chk("idle_ignores_right", player_x, 7);
        chk("idle_grn", grn, grn_map(0, 0, 0));

        start = 1; tick(); start = 0;
        chk("start_px", player_x, 7);
        chk("start_py", player_y, 14);
        move(0, 1, 2);
        move(1, 0, 1);
        chk("rrl_px", player_x, 8);
        chk("aim_grn", grn, grn_map(8, 14, 1));
        chk("aim_red", red, red_map(7, 1));
        move(1, 0, 5);
        chk("floor_px", player_x, 4);
        move(0, 1, 7);
        chk("ceiling_reach", player_x, 11);
        move(0, 1, 1);
        chk("ceiling_held", player_x, 11);
        move(1, 0, 3);
        chk("back_to_8", player_x, 8);
        exp_px = 8;
        chk("lfsr_model", check, m);

        take_shot(0);
        move(1, 1, 1);
        chk("lr_no_move", player_x, 8);
        take_shot(1);
        move(1, 0, 4);
        exp_px = 4;
        take_shot(0);
        move(0, 1, 7);
        exp_px = 11;
        take_shot(0);
        take_shot(0);

        chk("over_shots", shots_num, 5);
        shoot = 1; tick(); shoot = 0;
        tick();
        chk("over_ignore_shoot", shots_num, 5);
        chk("over_score_held", score, exp_score);
        move(1, 0, 1);
        chk("over_ignore_left", player_x, 11);

        start = 1; tick(); start = 0;
        chk("restart_score", score, 0);
        chk("restart_shots", shots_num, 0);
        chk("restart_px", player_x, 7);
        chk("restart_py", player_y, 14);

        shoot = 1; tick(); shoot = 0;
        repeat (5) tick();
        chk("midflight_py", player_y, 9);
        RST = 0;
        #1;
        chk("async_score", score, 0);
        chk("async_shots", shots_num, 0);
        chk("async_px", player_x, 7);
        chk("async_py", player_y, 14);
        chk("async_gk", goalkeeper_x, 7);
        chk("async_check", check, 0);
        chk("async_grn", grn, grn_map(0, 0, 0));
        chk("async_red", red, red_map(0, 0));
        tick();
        RST = 1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
